// File: rtl/gpr_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// gpr_write_arbiter_if
// Bundle of the GPR writeback arbiter's handshake and register-file signals.
//
//   alu_wb_valid/ready/dest/data : requester 0, ALU writeback
//   mem_wb_valid/ready/dest/data : requester 1, load writeback
//   issue_valid/ready/dest       : scoreboard reservation from decode
//   reg_write_en/dest/data       : registered GPR write port
//   busy_mask                    : registered pending-write flag per register
//
// modport slave  : the arbiter
// modport master : the surrounding pipeline (requesters, decode, GPR file)
// DATA_W / ADDR_W must match the parameters of the attached arbiter.
// ---------------------------------------------------------------------------
interface gpr_write_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic                     alu_wb_valid;
    logic                     alu_wb_ready;
    logic [ADDR_W-1:0]        alu_wb_dest;
    logic [DATA_W-1:0]        alu_wb_data;

    logic                     mem_wb_valid;
    logic                     mem_wb_ready;
    logic [ADDR_W-1:0]        mem_wb_dest;
    logic [DATA_W-1:0]        mem_wb_data;

    logic                     issue_valid;
    logic                     issue_ready;
    logic [ADDR_W-1:0]        issue_dest;

    logic                     reg_write_en;
    logic [ADDR_W-1:0]        reg_write_dest;
    logic [DATA_W-1:0]        reg_write_data;

    logic [(1<<ADDR_W)-1:0]   busy_mask;

    modport slave (
        input  alu_wb_valid, alu_wb_dest, alu_wb_data,
        output alu_wb_ready,
        input  mem_wb_valid, mem_wb_dest, mem_wb_data,
        output mem_wb_ready,
        input  issue_valid, issue_dest,
        output issue_ready,
        output reg_write_en, reg_write_dest, reg_write_data,
        output busy_mask
    );

    modport master (
        output alu_wb_valid, alu_wb_dest, alu_wb_data,
        input  alu_wb_ready,
        output mem_wb_valid, mem_wb_dest, mem_wb_data,
        input  mem_wb_ready,
        output issue_valid, issue_dest,
        input  issue_ready,
        input  reg_write_en, reg_write_dest, reg_write_data,
        input  busy_mask
    );
endinterface

// File: rtl/gpr_write_arbiter.sv
// ---------------------------------------------------------------------------
// gpr_write_arbiter
// Arbitrates the ALU and load writebacks onto the single GPR write port
// (one write per cycle, latency 1) and keeps a per-register busy mask that
// decode uses to reserve destinations.
//
// Ports:
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset; also forces all readies low
//   bus : gpr_write_arbiter_if.slave (requesters, issue, GPR write port,
//         busy_mask)
//
// Parameters: DATA_W (GPR data width), ADDR_W (GPR index width).
//
// Build option: define GPR_R0_ZERO_EN to make R0 hard-wired zero. Writebacks
// to R0 are still accepted but produce no GPR write, R0 is never busy and
// an issue to R0 is always ready.
// ---------------------------------------------------------------------------
module gpr_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    gpr_write_arbiter_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    logic              ptr;          // 0: ALU wins next contest, 1: MEM
    logic              gnt_alu_p0;
    logic              gnt_mem_p0;
    logic              issue_rdy_p0;
    logic              vld_p0;       // a writeback is accepted this cycle
    logic              wr_en_p0;     // the accepted writeback reaches the GPR
    logic [ADDR_W-1:0] wr_dest_p0;
    logic [DATA_W-1:0] wr_data_p0;
    logic              iss_vld_p0;
    logic [NREG-1:0]   busy_nxt_p0;

    // ---- stage p0: grant, issue check, next busy mask (combinational) ----
    // Grants depend only on the valids, the pointer and rst, never on data.
    always_comb begin
        gnt_alu_p0 = 1'b0;
        gnt_mem_p0 = 1'b0;
        if (!rst) begin
            if (bus.alu_wb_valid && bus.mem_wb_valid) begin
                gnt_alu_p0 = ~ptr;
                gnt_mem_p0 = ptr;
            end else begin
                gnt_alu_p0 = bus.alu_wb_valid;
                gnt_mem_p0 = bus.mem_wb_valid;
            end
        end
    end

    always_comb begin
        issue_rdy_p0 = ~bus.busy_mask[bus.issue_dest];
`ifdef GPR_R0_ZERO_EN
        if (bus.issue_dest == '0) issue_rdy_p0 = 1'b1;
`endif
        if (rst) issue_rdy_p0 = 1'b0;
    end

    assign bus.alu_wb_ready = gnt_alu_p0;
    assign bus.mem_wb_ready = gnt_mem_p0;
    assign bus.issue_ready  = issue_rdy_p0;

    always_comb begin
        vld_p0     = gnt_alu_p0 | gnt_mem_p0;
        wr_dest_p0 = gnt_mem_p0 ? bus.mem_wb_dest : bus.alu_wb_dest;
        wr_data_p0 = gnt_mem_p0 ? bus.mem_wb_data : bus.alu_wb_data;
`ifdef GPR_R0_ZERO_EN
        wr_en_p0   = vld_p0 && (wr_dest_p0 != '0);
`else
        wr_en_p0   = vld_p0;
`endif
        iss_vld_p0 = bus.issue_valid & issue_rdy_p0;

        // Clear first, then set, so a same-cycle reservation of the index
        // being written back survives.
        busy_nxt_p0 = bus.busy_mask;
        if (vld_p0)     busy_nxt_p0[wr_dest_p0]     = 1'b0;
        if (iss_vld_p0) busy_nxt_p0[bus.issue_dest] = 1'b1;
`ifdef GPR_R0_ZERO_EN
        busy_nxt_p0[0] = 1'b0;
`endif
    end

    // ---- stage p1: registered GPR write port, busy mask and pointer ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr                <= 1'b0;
            bus.reg_write_en   <= 1'b0;
            bus.reg_write_dest <= '0;
            bus.reg_write_data <= '0;
            bus.busy_mask      <= '0;
        end else begin
            // Only a contested cycle moves the pointer.
            if (bus.alu_wb_valid && bus.mem_wb_valid) ptr <= ~ptr;
            bus.reg_write_en <= wr_en_p0;
            if (wr_en_p0) begin
                bus.reg_write_dest <= wr_dest_p0;
                bus.reg_write_data <= wr_data_p0;
            end
            bus.busy_mask <= busy_nxt_p0;
        end
    end
endmodule

// File: tb/tb_gpr_write_arbiter.sv
module tb_gpr_write_arbiter;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpr_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    gpr_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        en;
        logic [2:0]  dest;
        logic [15:0] data;
        logic [7:0]  busy;
    } obs_t;

    obs_t exp_q[$];

    // reference model state
    logic        m_ptr;
    logic [7:0]  m_busy;
    logic [2:0]  m_wdest;
    logic [15:0] m_wdata;

    function automatic obs_t observed();
        obs_t o;
        o.en   = bus.reg_write_en;
        o.dest = bus.reg_write_dest;
        o.data = bus.reg_write_data;
        o.busy = bus.busy_mask;
        return o;
    endfunction

    function automatic logic [2:0] readies();
        return {bus.alu_wb_ready, bus.mem_wb_ready, bus.issue_ready};
    endfunction

    task automatic drive(input logic av, input logic [2:0] ad, input logic [15:0] adat,
                         input logic mv, input logic [2:0] md, input logic [15:0] mdat,
                         input logic iv, input logic [2:0] id);
        bus.alu_wb_valid = av; bus.alu_wb_dest = ad; bus.alu_wb_data = adat;
        bus.mem_wb_valid = mv; bus.mem_wb_dest = md; bus.mem_wb_data = mdat;
        bus.issue_valid  = iv; bus.issue_dest  = id;
    endtask

    task automatic model_reset();
        m_ptr = 1'b0; m_busy = '0; m_wdest = '0; m_wdata = '0;
        exp_q.delete();
    endtask

    // Predict this cycle's readies and push the state expected after the edge.
    task automatic predict(output logic [2:0] rdy);
        logic ga, gm, ir, en;
        logic [2:0] d;
        logic [15:0] dat;
        logic [7:0] nb;
        obs_t e;
        ga = bus.alu_wb_valid && (!bus.mem_wb_valid || !m_ptr);
        gm = bus.mem_wb_valid && (!bus.alu_wb_valid || m_ptr);
        ir = !m_busy[bus.issue_dest];
`ifdef GPR_R0_ZERO_EN
        if (bus.issue_dest == 3'd0) ir = 1'b1;
`endif
        rdy = {ga, gm, ir};
        d   = gm ? bus.mem_wb_dest : bus.alu_wb_dest;
        dat = gm ? bus.mem_wb_data : bus.alu_wb_data;
        en  = ga || gm;
`ifdef GPR_R0_ZERO_EN
        if (d == 3'd0) en = 1'b0;
`endif
        nb = m_busy;
        if (ga || gm) nb[d] = 1'b0;
        if (bus.issue_valid && ir) nb[bus.issue_dest] = 1'b1;
`ifdef GPR_R0_ZERO_EN
        nb[0] = 1'b0;
`endif
        if (en) begin m_wdest = d; m_wdata = dat; end
        if (bus.alu_wb_valid && bus.mem_wb_valid) m_ptr = !m_ptr;
        m_busy = nb;
        e.en = en; e.dest = m_wdest; e.data = m_wdata; e.busy = m_busy;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [2:0] rdy;
        obs_t o;
        rst = 1'b1;
        drive(1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, 1, 3'd3);
        #3;
        rdy = readies();
        checks++;
        if (rdy !== 3'b000) begin failures++; $display("FAIL reset_readies got=%b exp=000", rdy); end
        o = observed();
        checks++;
        if (o !== obs_t'(0)) begin failures++; $display("FAIL reset_outputs got=%h exp=0", o); end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
    endtask

    // ALU alone, dest 3, data BEEF; then an idle cycle holding the write port.
    task automatic test_single();
        logic [2:0] rdy;
        obs_t o, e;
        drive(1, 3'd3, 16'hBEEF, 0, 3'd6, 16'h0BAD, 0, 3'd0);
        #1; predict(rdy);
        checks++;
        if (readies() !== rdy) begin failures++; $display("FAIL single_rdy got=%b exp=%b", readies(), rdy); end
        checks++;
        if (bus.alu_wb_ready !== 1'b1) begin failures++; $display("FAIL single_alu_ready got=%b exp=1", bus.alu_wb_ready); end
        @(posedge clk); #1;
        e = exp_q.pop_front(); o = observed();
        checks++;
        if (o !== e) begin failures++; $display("FAIL single_wr got=%h exp=%h", o, e); end
        checks++;
        if ({o.en, o.dest, o.data} !== {1'b1, 3'd3, 16'hBEEF})
            begin failures++; $display("FAIL single_beef got=%b/%0d/%h exp=1/3/beef", o.en, o.dest, o.data); end
        drive(0, 3'd1, 16'h5555, 0, 3'd2, 16'h6666, 0, 3'd0);
        #1; predict(rdy);
        checks++;
        if (readies() !== rdy) begin failures++; $display("FAIL idle_rdy got=%b exp=%b", readies(), rdy); end
        @(posedge clk); #1;
        e = exp_q.pop_front(); o = observed();
        checks++;
        if (o !== e) begin failures++; $display("FAIL idle_hold got=%h exp=%h", o, e); end
    endtask

    // Both valid for 4 cycles after reset: ALU, MEM, ALU, MEM with no bubble.
    task automatic test_back_to_back();
        logic [2:0] rdy;
        obs_t o, e;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'(i), 16'hA000 + 16'(i), 1, 3'(4 + i), 16'hB000 + 16'(i * 3), 0, 3'd0);
            #1; predict(rdy);
            checks++;
            if (readies() !== rdy) begin failures++; $display("FAIL b2b_rdy cyc=%0d got=%b exp=%b", i, readies(), rdy); end
            checks++;
            if ({bus.alu_wb_ready, bus.mem_wb_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                begin failures++; $display("FAIL b2b_grant cyc=%0d got=%b%b", i, bus.alu_wb_ready, bus.mem_wb_ready); end
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = observed();
            checks++;
            if (o !== e || o.en !== 1'b1) begin failures++; $display("FAIL b2b_wr cyc=%0d got=%h exp=%h", i, o, e); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reserve 5, re-issue 5 (blocked), MEM writeback to 5 clears it;
    // then same-cycle issue and ALU writeback to 2 leaves 2 busy.
    task automatic test_busy();
        logic [2:0] rdy;
        obs_t o, e;
        logic [7:0] want_busy [4] = '{8'h20, 8'h20, 8'h00, 8'h04};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1, 3'd5);
                1: drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1, 3'd5);
                2: drive(0, 3'd0, 16'h0, 1, 3'd5, 16'hC0DE, 0, 3'd0);
                default: drive(1, 3'd2, 16'h2A2A, 0, 3'd0, 16'h0, 1, 3'd2);
            endcase
            #1; predict(rdy);
            checks++;
            if (readies() !== rdy) begin failures++; $display("FAIL busy_rdy cyc=%0d got=%b exp=%b", i, readies(), rdy); end
            if (i == 1) begin
                checks++;
                if (bus.issue_ready !== 1'b0) begin failures++; $display("FAIL busy_reissue got=%b exp=0", bus.issue_ready); end
            end
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = observed();
            checks++;
            if (o !== e) begin failures++; $display("FAIL busy_wr cyc=%0d got=%h exp=%h", i, o, e); end
            checks++;
            if (o.busy !== want_busy[i]) begin failures++; $display("FAIL busy_mask cyc=%0d got=%h exp=%h", i, o.busy, want_busy[i]); end
        end
        checks++;
        if ({bus.reg_write_en, bus.reg_write_dest} !== {1'b1, 3'd2})
            begin failures++; $display("FAIL busy_same_cycle_wr got=%b/%0d exp=1/2", bus.reg_write_en, bus.reg_write_dest); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Contested burst (pointer ends at MEM), async reset mid-cycle, then ALU first.
    task automatic test_async_reset();
        logic [2:0] rdy;
        obs_t o, e;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'(1 + i), 16'hD000 + 16'(i), 1, 3'(4 + i), 16'hE000 + 16'(i), 1, 3'd6);
            #1; predict(rdy);
            checks++;
            if (readies() !== rdy) begin failures++; $display("FAIL arst_rdy cyc=%0d got=%b exp=%b", i, readies(), rdy); end
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = observed();
            checks++;
            if (o !== e) begin failures++; $display("FAIL arst_wr cyc=%0d got=%h exp=%h", i, o, e); end
        end
        #2;
        rst = 1'b1;
        #1;
        o = observed();
        checks++;
        if (o !== obs_t'(0)) begin failures++; $display("FAIL arst_immediate got=%h exp=0", o); end
        checks++;
        if (readies() !== 3'b000) begin failures++; $display("FAIL arst_readies got=%b exp=000", readies()); end
        @(posedge clk); #1;
        o = observed();
        checks++;
        if (o !== obs_t'(0)) begin failures++; $display("FAIL arst_dropped got=%h exp=0", o); end
        rst = 1'b0;
        model_reset();
        drive(1, 3'd7, 16'h7777, 1, 3'd3, 16'h3333, 0, 3'd0);
        #1; predict(rdy);
        checks++;
        if ({bus.alu_wb_ready, bus.mem_wb_ready} !== 2'b10)
            begin failures++; $display("FAIL arst_alu_first got=%b%b exp=10", bus.alu_wb_ready, bus.mem_wb_ready); end
        @(posedge clk); #1;
        e = exp_q.pop_front(); o = observed();
        checks++;
        if (o !== e) begin failures++; $display("FAIL arst_post_wr got=%h exp=%h", o, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ALU writeback and issue to R0.
    task automatic test_r0();
        logic [2:0] rdy;
        obs_t o, e;
        drive(1, 3'd0, 16'h1234, 0, 3'd0, 16'h0, 1, 3'd0);
        #1; predict(rdy);
        checks++;
        if (bus.alu_wb_ready !== 1'b1) begin failures++; $display("FAIL r0_ready got=%b exp=1", bus.alu_wb_ready); end
        @(posedge clk); #1;
        e = exp_q.pop_front(); o = observed();
        checks++;
        if (o !== e) begin failures++; $display("FAIL r0_wr got=%h exp=%h", o, e); end
        checks++;
`ifdef GPR_R0_ZERO_EN
        if ({o.en, o.busy[0]} !== 2'b00) begin failures++; $display("FAIL r0_zero got=en%b busy0=%b exp=0/0", o.en, o.busy[0]); end
`else
        if ({o.en, o.dest, o.data, o.busy[0]} !== {1'b1, 3'd0, 16'h1234, 1'b1})
            begin failures++; $display("FAIL r0_plain got=%b/%0d/%h busy0=%b exp=1/0/1234/1", o.en, o.dest, o.data, o.busy[0]); end
`endif
        drive(0, 0, 0, 0, 0, 0, 1, 3'd0);
        #1; predict(rdy);
        checks++;
        if (readies() !== rdy) begin failures++; $display("FAIL r0_issue_rdy got=%b exp=%b", readies(), rdy); end
        @(posedge clk); #1;
        e = exp_q.pop_front(); o = observed();
        checks++;
        if (o !== e) begin failures++; $display("FAIL r0_after got=%h exp=%h", o, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_busy();
        test_async_reset();
        test_r0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gpr_write_arbiter.md
GPR_WRITE_ARBITER -- requirements
Module: gpr_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning GPR data width.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning GPR index width; register count is 2**ADDR_W.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports alu_wb_valid (input, 1), alu_wb_ready (output, 1), alu_wb_dest (input, ADDR_W) and alu_wb_data (input, DATA_W): requester 0, the ALU writeback.
REQ-006 SHALL have ports mem_wb_valid (input, 1), mem_wb_ready (output, 1), mem_wb_dest (input, ADDR_W) and mem_wb_data (input, DATA_W): requester 1, the load writeback.
REQ-007 SHALL have ports issue_valid (input, 1), issue_ready (output, 1) and issue_dest (input, ADDR_W): the scoreboard reservation request from decode.
REQ-008 SHALL have ports reg_write_en (output, 1), reg_write_dest (output, ADDR_W) and reg_write_data (output, DATA_W): the GPR write port, all registered.
REQ-009 SHALL have port busy_mask, output, 2**ADDR_W bits: pending-write flag per register, registered.

Function
REQ-010 SHALL accept a requester transfer only in a cycle where its valid and ready are both 1.
REQ-011 SHALL grant at most one requester per cycle; the ready of a non-granted requester is 0.
REQ-012 SHALL drive each ready combinationally from the valids and the priority pointer, independent of the data inputs.
REQ-013 SHALL give the grant to the only valid requester when exactly one valid is 1.
REQ-014 SHALL, when both valids are 1, grant the requester named by the 1-bit priority pointer (0=ALU, 1=MEM).
REQ-015 SHALL toggle the pointer to the other requester after a contested grant and leave it unchanged after an uncontested grant.
REQ-016 SHALL register the accepted dest and data so that reg_write_en=1 with those values exactly one cycle after acceptance (latency 1).
REQ-017 SHALL drive reg_write_en=0 in any cycle following a cycle with no accepted transfer, and SHALL hold reg_write_dest and reg_write_data at their last values.
REQ-018 SHALL sustain one write per cycle with no bubble under back-to-back requests.
REQ-019 SHALL drive issue_ready = ~busy_mask[issue_dest] from the registered mask.
REQ-020 SHALL set busy_mask[issue_dest] on an accepted issue and clear busy_mask[d] on an accepted writeback with dest d, both effective the next cycle.
REQ-021 SHALL let the set win when a set and a clear target the same index in the same cycle.
REQ-022 SHALL leave busy_mask unchanged on a writeback to an index that is not busy; the write itself proceeds.
REQ-023 SHALL let a requester's valid and payload change freely while that requester is not granted; no stability is required before acceptance.

Reset
REQ-024 SHALL, while rst=1 and independent of clk, force reg_write_en=0, reg_write_dest=0, reg_write_data=0, busy_mask=0 and pointer=0 (ALU first).
REQ-025 SHALL drop a transfer that is accepted in the cycle in which rst asserts; no write for it appears after reset.
REQ-026 SHALL drive alu_wb_ready, mem_wb_ready and issue_ready to 0 while rst=1.

Configuration
REQ-027 SHALL use the macro GPR_R0_ZERO_EN to select R0 write handling.
REQ-028 SHALL, with GPR_R0_ZERO_EN defined, still accept writebacks to dest 0 normally but produce reg_write_en=0 for them, and SHALL hold busy_mask[0] at 0 and issue_ready=1 for issue_dest=0.
REQ-029 SHALL, without GPR_R0_ZERO_EN, treat index 0 identically to every other register.

Verification
REQ-030 SHALL cover: ALU only, dest=3, data=16'hBEEF -> alu_wb_ready=1; next cycle reg_write_en=1, dest=3, data=16'hBEEF.
REQ-031 SHALL cover: both valid for 4 cycles after reset, distinct data -> grants ALU, MEM, ALU, MEM; 4 consecutive writes with no bubble.
REQ-032 SHALL cover: issue dest=5 -> busy_mask=8'h20; second issue to 5 -> issue_ready=0; MEM writeback to 5 accepted -> busy_mask=8'h00 next cycle.
REQ-033 SHALL cover: same-cycle issue dest=2 (not busy) and ALU writeback dest=2 -> write occurs and busy_mask[2]=1 afterwards.
REQ-034 SHALL cover: rst asserted mid-burst, asynchronously between edges -> outputs and busy_mask go to 0 immediately; after release the ALU wins the first contested grant.
REQ-035 SHALL cover: with GPR_R0_ZERO_EN defined, ALU writeback dest=0 -> alu_wb_ready=1 and reg_write_en stays 0; without the macro, same stimulus -> reg_write_en=1, dest=0.
